// File: rtl/barrett_mu_precomp.sv
// Barrett constant precomputation: k = clog2(m) and mu = floor(2^(2k) / m)
// via bit-serial restoring division, one quotient bit per clock.
module barrett_mu_precomp #(
    parameter int unsigned DATA_LENGTH = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [DATA_LENGTH-1:0] m_i,
    output logic                   busy_o,
    output logic                   valid_o,
    output logic                   err_o,
    output logic [DATA_LENGTH-1:0] m_o,
    output logic [DATA_LENGTH-1:0] mu_o,
    output logic [DATA_LENGTH-1:0] m_bl_o
);

    localparam int unsigned KW = $clog2(DATA_LENGTH);
    localparam int unsigned CW = KW + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOG,
        DIV,
        DONE
    } state_t;

    state_t                 state;
    logic [DATA_LENGTH:0]   r;
    logic [DATA_LENGTH-1:0] q;
    logic [KW-1:0]          k;
    logic [CW-1:0]          cnt;

    logic [DATA_LENGTH-1:0] m_dec;
    logic [KW-1:0]          k_enc;
    logic                   m_bad;
    logic [DATA_LENGTH:0]   r_sh;
    logic [DATA_LENGTH:0]   r_nx;
    logic [DATA_LENGTH-1:0] q_nx;
    logic                   ge;

    // clog2(m) is one past the highest set bit of m-1
    always_comb begin
        m_dec = m_o - DATA_LENGTH'(1);
        k_enc = '0;
        for (int unsigned i = 0; i < DATA_LENGTH; i++) begin
            if (m_dec[i]) k_enc = KW'(i + 1);
        end
        m_bad = (m_o < DATA_LENGTH'(2)) || m_o[DATA_LENGTH-1];
    end

    // Dividend 2^(2k) has its single one bit at the first iteration
    always_comb begin
        r_sh = (r << 1) | {{DATA_LENGTH{1'b0}}, (cnt == {k, 1'b0})};
        ge   = (r_sh >= {1'b0, m_o});
        r_nx = ge ? (r_sh - {1'b0, m_o}) : r_sh;
        q_nx = {q[DATA_LENGTH-2:0], ge};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            busy_o  <= 1'b0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            m_o     <= '0;
            mu_o    <= '0;
            m_bl_o  <= '0;
            r       <= '0;
            q       <= '0;
            k       <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    valid_o <= 1'b0;
                    if (start_i) begin
                        m_o    <= m_i;
                        err_o  <= 1'b0;
                        busy_o <= 1'b1;
                        state  <= LOG;
                    end
                end
                LOG: begin
                    mu_o   <= '0;
                    m_bl_o <= '0;
                    r      <= '0;
                    q      <= '0;
                    k      <= k_enc;
                    cnt    <= {k_enc, 1'b0};
                    if (m_bad) begin
                        err_o  <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= DONE;
                    end else begin
                        state  <= DIV;
                    end
                end
                DIV: begin
                    r   <= r_nx;
                    q   <= q_nx;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        mu_o    <= q_nx;
                        m_bl_o  <= DATA_LENGTH'(k);
                        valid_o <= 1'b1;
                        busy_o  <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    // Normal path pulsed valid on entry; error path pulses here, one edge later
                    valid_o <= err_o;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
